rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_if.sv | 31 +++
 rtl/rom_arbiter.sv | 103 ++++++++++
 tb/tb_rom_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - fetch/data request, response and ROM-side signals of the ROM arbiter
interface rom_arbiter_if;
   logic        if_valid;
   logic [30:0] if_addr;
   logic        if_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        d_valid;
   logic [30:0] d_addr;
   logic        d_ready;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic        d_rsp_err;
   logic [30:0] rom_addr;
   logic [31:0] rom_data;

   // requesters and the ROM model sit on this side
   modport master (
      output if_valid, if_addr, d_valid, d_addr, rom_data,
      input  if_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  d_ready, d_rsp_valid, d_rsp_data, d_rsp_err, rom_addr
   );

   // the arbiter sits on this side
   modport slave (
      input  if_valid, if_addr, d_valid, d_addr, rom_data,
      output if_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output d_ready, d_rsp_valid, d_rsp_data, d_rsp_err, rom_addr
   );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port (fetch/data) arbiter onto a combinational program ROM; ROM_ARB_FAIR_EN selects round-robin
module rom_arbiter #(
   parameter int ROM_SIZE   = 256,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          reset,
   rom_arbiter_if.slave bus
);

   typedef enum logic {IDLE, RESP} state_t;

   localparam logic [29:0] ROM_WORDS = 30'(ROM_SIZE);

   state_t      state;
   logic        owner_if;   // pending response belongs to the fetch port
   logic        err_q;      // pending response is out-of-range or misaligned
   logic [30:0] addr_q;

   logic        conflict;
   logic        fetch_wins;
   logic        grant_if;
   logic        grant_d;
   logic        accept;
   logic [30:0] acc_addr;
   logic        acc_bad;

`ifdef ROM_ARB_FAIR_EN
   logic last_if;   // fetch won the most recent conflict

   // round-robin pointer: loser of the last conflict wins the next one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_if <= 1'b1;
      end else if (conflict) begin
         last_if <= grant_if;
      end
   end

   assign fetch_wins = ~last_if;
`else
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;

   // count consecutive lost conflicts of the fetch port, saturating at the guard limit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!bus.if_valid || grant_if) begin
         starve_cnt <= '0;
      end else if (conflict && starve_cnt != SMAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign fetch_wins = (starve_cnt == SMAX);
`endif

   // grant selection and the address/error of whichever request is accepted this cycle
   always_comb begin
      conflict = bus.if_valid & bus.d_valid;
      grant_if = bus.if_valid & (~bus.d_valid | fetch_wins);
      grant_d  = bus.d_valid & ~grant_if;
      accept   = grant_if | grant_d;
      acc_addr = grant_if ? bus.if_addr : bus.d_addr;
      acc_bad  = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr[30:2]} >= ROM_WORDS);
   end

   // IDLE/RESP FSM; registers the accepted address, owner and error flag for the 1-cycle response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner_if <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) state <= RESP;
            RESP: if (!accept) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (accept) begin
            owner_if <= grant_if;
            err_q    <= acc_bad;
            addr_q   <= acc_addr;
         end
      end
   end

   assign bus.if_ready     = grant_if;
   assign bus.d_ready      = grant_d;
   assign bus.rom_addr     = addr_q;

   assign bus.if_rsp_valid = (state == RESP) & owner_if;
   assign bus.d_rsp_valid  = (state == RESP) & ~owner_if;
   assign bus.if_rsp_err   = bus.if_rsp_valid & err_q;
   assign bus.d_rsp_err    = bus.d_rsp_valid & err_q;
   assign bus.if_rsp_data  = (bus.if_rsp_valid & ~err_q) ? bus.rom_data : 32'h0;
   assign bus.d_rsp_data   = (bus.d_rsp_valid & ~err_q) ? bus.rom_data : 32'h0;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fails = 0;

   rom_arbiter_if bus();

   rom_arbiter #(.ROM_SIZE(256), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // ROM model: word w holds 0xA500_0000 | w
   function automatic logic [31:0] rom_word(input logic [30:0] a);
      return 32'hA500_0000 | {9'b0, a[24:2]};
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [30:0] ia, input logic dv, input logic [30:0] da);
      bus.if_valid = iv;
      bus.if_addr  = ia;
      bus.d_valid  = dv;
      bus.d_addr   = da;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic exp_if;

      drive(1'b0, '0, 1'b0, '0);
      step();
      step();
      check("reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      check("reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
      check("reset if_rsp_err", 32'(bus.if_rsp_err), 32'd0);
      check("reset d_rsp_err", 32'(bus.d_rsp_err), 32'd0);
      check("reset if_rsp_data", bus.if_rsp_data, 32'd0);
      check("reset d_rsp_data", bus.d_rsp_data, 32'd0);
      check("reset rom_addr", 32'(bus.rom_addr), 32'd0);
      reset = 1'b0;

      // single fetch of word 2
      drive(1'b1, 31'h8, 1'b0, '0);
      #1;
      check("fetch if_ready", 32'(bus.if_ready), 32'd1);
      check("fetch d_ready", 32'(bus.d_ready), 32'd0);
      step();
      drive(1'b0, '0, 1'b0, '0);
      check("fetch if_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
      check("fetch if_rsp_data", bus.if_rsp_data, 32'hA500_0002);
      check("fetch if_rsp_err", 32'(bus.if_rsp_err), 32'd0);
      check("fetch d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
      check("fetch rom_addr", 32'(bus.rom_addr), 32'h8);
      step();
      check("idle if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      check("idle rom_addr hold", 32'(bus.rom_addr), 32'h8);

      // continuous conflict: fixed D,D,D,D,IF / fair D,IF alternating
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 31'(4 * i), 1'b1, 31'(32'h100 + 4 * i));
`ifdef ROM_ARB_FAIR_EN
         exp_if = (i % 2 == 1);
`else
         exp_if = (i % 5 == 4);
`endif
         #1;
         check($sformatf("conflict%0d if_ready", i), 32'(bus.if_ready), 32'(exp_if));
         check($sformatf("conflict%0d d_ready", i), 32'(bus.d_ready), 32'(!exp_if));
         step();
         check($sformatf("conflict%0d if_rsp_valid", i), 32'(bus.if_rsp_valid), 32'(exp_if));
         check($sformatf("conflict%0d d_rsp_valid", i), 32'(bus.d_rsp_valid), 32'(!exp_if));
         if (exp_if)
            check($sformatf("conflict%0d if_rsp_data", i), bus.if_rsp_data, 32'hA500_0000 + 32'(i));
         else
            check($sformatf("conflict%0d d_rsp_data", i), bus.d_rsp_data, 32'hA500_0040 + 32'(i));
      end
      drive(1'b0, '0, 1'b0, '0);
      step();

      // data port: out of range, misaligned, last valid word
      drive(1'b0, '0, 1'b1, 31'h400);
      step();
      check("oor d_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
      check("oor d_rsp_data", bus.d_rsp_data, 32'd0);
      check("oor d_rsp_err", 32'(bus.d_rsp_err), 32'd1);
      drive(1'b0, '0, 1'b1, 31'h6);
      step();
      check("misalign d_rsp_err", 32'(bus.d_rsp_err), 32'd1);
      check("misalign d_rsp_data", bus.d_rsp_data, 32'd0);
      drive(1'b0, '0, 1'b1, 31'h3FC);
      step();
      check("lastword d_rsp_err", 32'(bus.d_rsp_err), 32'd0);
      check("lastword d_rsp_data", bus.d_rsp_data, 32'hA500_00FF);
      drive(1'b1, 31'h401, 1'b0, '0);
      step();
      check("if oor if_rsp_err", 32'(bus.if_rsp_err), 32'd1);
      check("if oor if_rsp_data", bus.if_rsp_data, 32'd0);
      drive(1'b0, '0, 1'b0, '0);
      step();

      // reset the cycle after a grant
      drive(1'b1, 31'h10, 1'b0, '0);
      step();
      check("pre-reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("async reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      check("async reset if_rsp_data", bus.if_rsp_data, 32'd0);
      check("async reset rom_addr", 32'(bus.rom_addr), 32'd0);
      drive(1'b1, 31'h14, 1'b1, 31'h18);
      step();
      check("in-reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      check("in-reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
      drive(1'b0, '0, 1'b0, '0);
      reset = 1'b0;
      step();
      check("post-reset if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      check("post-reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
      drive(1'b1, 31'h24, 1'b1, 31'h20);
      #1;
      check("post-reset conflict d_ready", 32'(bus.d_ready), 32'd1);
      check("post-reset conflict if_ready", 32'(bus.if_ready), 32'd0);
      step();
      drive(1'b0, '0, 1'b0, '0);
      check("post-reset d_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
      check("post-reset d_rsp_data", bus.d_rsp_data, 32'hA500_0008);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
